button_event: RTL and testbench

//  Classifies debounced push-button edges into user events: short click, long press and auto-repeat.

---
 rtl/button_event_pkg.sv | 16 +
 rtl/button_event_tick_gen.sv | 28 ++
 rtl/button_event.sv | 104 ++++++++++
 tb/tb_button_event.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// Shared definitions for the push-button event classifier:
// FSM encoding and default timing parameters.
package button_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [15:0] DEF_TICK_DIV     = 16'd50000;
  localparam logic [7:0]  DEF_LONG_TICKS   = 8'd100;
  localparam logic [7:0]  DEF_REPEAT_TICKS = 8'd20;
  localparam int          DEF_CNT_W        = 8;

endpackage

// File: rtl/button_event_tick_gen.sv
// Timing prescaler: free-running 0..TICK_DIV-1 counter whose phase can be
// re-referenced by CLR; TICK marks the last count of each period.
module tick_gen
  import button_event_pkg::*;
#(
  parameter logic [15:0] TICK_DIV = DEF_TICK_DIV
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  output logic TICK
);

  logic [15:0] count_reg;

  assign TICK = (count_reg == TICK_DIV - 16'd1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_reg <= '0;
    end else if (CLR || TICK) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 16'd1;
    end
  end

endmodule

// File: rtl/button_event.sv
// Turns debounced press/release pulses into click, long-press and
// auto-repeat pulses plus a held level; all outputs registered.
module button_event
  import button_event_pkg::*;
#(
  parameter logic [15:0]      TICK_DIV     = DEF_TICK_DIV,
  parameter int               CNT_W        = DEF_CNT_W,
  parameter logic [CNT_W-1:0] LONG_TICKS   = CNT_W'(DEF_LONG_TICKS),
  parameter logic [CNT_W-1:0] REPEAT_TICKS = CNT_W'(DEF_REPEAT_TICKS)
) (
  input  logic CLK,
  input  logic RST,
  input  logic PB_down,
  input  logic PB_up,
  output logic CLICK,
  output logic LONG,
  output logic REPEAT,
  output logic HELD
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             click_next, long_next, repeat_next, held_next;
  logic             press_clr;
  logic             tick;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (press_clr),
    .TICK (tick)
  );

  assign cnt_inc = cnt_reg + CNT_W'(1);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    click_next  = 1'b0;
    long_next   = 1'b0;
    repeat_next = 1'b0;
    press_clr   = 1'b0;
    // Release is checked before the tick so it wins a same-cycle collision.
    case (state_reg)
      ST_PRESS: begin
        if (PB_up) begin
          state_next = ST_IDLE;
          click_next = 1'b1;
        end else if (tick) begin
          if (cnt_inc == LONG_TICKS) begin
            long_next  = 1'b1;
            cnt_next   = '0;
            state_next = ST_HOLD;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      ST_HOLD: begin
        if (PB_up) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          if (cnt_inc == REPEAT_TICKS) begin
            repeat_next = 1'b1;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      default: begin
        // Illegal encodings recover through the idle branch.
        state_next = ST_IDLE;
        if (PB_down && !PB_up) begin
          state_next = ST_PRESS;
          cnt_next   = '0;
          press_clr  = 1'b1;
        end
      end
    endcase
    held_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      CLICK     <= 1'b0;
      LONG      <= 1'b0;
      REPEAT    <= 1'b0;
      HELD      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      CLICK     <= click_next;
      LONG      <= long_next;
      REPEAT    <= repeat_next;
      HELD      <= held_next;
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Randomized and directed bench for button_event: an event-time reference
// model feeds a scoreboard that a negedge monitor drains cycle by cycle.
module tb_button_event;

  localparam int D = 4;
  localparam int L = 3;
  localparam int R = 2;

  typedef struct {
    int         cyc;
    logic [2:0] kind;   // {REPEAT, LONG, CLICK}
  } ev_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic PB_down = 1'b0;
  logic PB_up = 1'b0;
  logic CLICK, LONG, REPEAT, HELD;

  int  n_checks = 0;
  int  n_fail = 0;
  bit  run = 1'b0;
  int  edge_idx = 0;
  int  mcyc = 0;
  bit  pressed = 1'b0;
  int  press_edge = 0;
  ev_t exp_q[$];
  bit  held_q[$];

  bit         mon_held;
  logic [2:0] mon_kexp, mon_kact;

  always #5 CLK = ~CLK;

  button_event #(
    .TICK_DIV     (16'd4),
    .CNT_W        (8),
    .LONG_TICKS   (8'd3),
    .REPEAT_TICKS (8'd2)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .PB_down (PB_down),
    .PB_up   (PB_up),
    .CLICK   (CLICK),
    .LONG    (LONG),
    .REPEAT  (REPEAT),
    .HELD    (HELD)
  );

  function automatic void push_ev(input int e, input logic [2:0] k);
    ev_t ev;
    ev.cyc  = e;
    ev.kind = k;
    exp_q.push_back(ev);
  endfunction

  // Event times follow from elapsed clock edges since the accepted press.
  function automatic void model_step(input bit d, input bit u);
    int el;
    if (pressed) begin
      el = edge_idx - press_edge;
      if (u) begin
        pressed = 1'b0;
        if (el <= L * D) push_ev(edge_idx, 3'b001);
      end else if (el == L * D) begin
        push_ev(edge_idx, 3'b010);
      end else if (el > L * D && ((el - L * D) % (R * D)) == 0) begin
        push_ev(edge_idx, 3'b100);
      end
    end else if (d && !u) begin
      pressed    = 1'b1;
      press_edge = edge_idx;
    end
    held_q.push_back(pressed);
    edge_idx++;
  endfunction

  task automatic drive(input bit d, input bit u, input bit r);
    @(negedge CLK);
    #1;
    if (r) begin
      RST     = 1'b1;
      PB_down = 1'b0;
      PB_up   = 1'b0;
      pressed = 1'b0;
      held_q.push_back(1'b0);
      edge_idx++;
      #1;
      n_checks++;
      if ({CLICK, LONG, REPEAT, HELD} !== 4'b0000) begin
        n_fail++;
        $display("FAIL async_reset edge=%0d got {click,long,rep,held}=%b want 0000",
                 edge_idx - 1, {CLICK, LONG, REPEAT, HELD});
      end
    end else begin
      RST     = 1'b0;
      PB_down = d;
      PB_up   = u;
      model_step(d, u);
    end
    run = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge CLK) begin
    if (run) begin
      n_checks++;
      if (held_q.size() == 0) begin
        n_fail++;
        $display("FAIL held_queue cyc=%0d got empty queue want one entry", mcyc);
      end else begin
        mon_held = held_q.pop_front();
        if (HELD !== mon_held) begin
          n_fail++;
          $display("FAIL held cyc=%0d got %b want %b", mcyc, HELD, mon_held);
        end
      end
      mon_kexp = 3'b000;
      if (exp_q.size() > 0 && exp_q[0].cyc == mcyc) begin
        mon_kexp = exp_q[0].kind;
        exp_q.delete(0);
      end
      mon_kact = {REPEAT, LONG, CLICK};
      n_checks++;
      if (mon_kact !== mon_kexp) begin
        n_fail++;
        $display("FAIL pulses cyc=%0d got {rep,long,click}=%b want %b",
                 mcyc, mon_kact, mon_kexp);
      end
      mcyc++;
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({CLICK, LONG, REPEAT, HELD} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state got {click,long,rep,held}=%b want 0000",
               {CLICK, LONG, REPEAT, HELD});
    end

    idle(3);
    // short click
    drive(1, 0, 0); idle(4); drive(0, 1, 0); idle(4);
    // long press with two repeats, released between repeats
    drive(1, 0, 0); idle(29); drive(0, 1, 0); idle(4);
    // release on the LONG tick
    drive(1, 0, 0); idle(11); drive(0, 1, 0); idle(4);
    // release on a REPEAT tick
    drive(1, 0, 0); idle(19); drive(0, 1, 0); idle(4);
    // reset mid-press, release afterwards
    drive(1, 0, 0); idle(5); drive(0, 0, 1); drive(0, 0, 1); idle(2); drive(0, 1, 0); idle(4);
    // extra press ignored while pressed
    drive(1, 0, 0); idle(7); drive(1, 0, 0); idle(6); drive(0, 1, 0); idle(4);
    // release alone and both together in idle
    drive(0, 1, 0); idle(2); drive(1, 1, 0); idle(3);
    // both together while pressed act as release
    drive(1, 0, 0); idle(3); drive(1, 1, 0); idle(3);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 23) == 0,
            $urandom_range(0, 399) == 0);
    end
    idle(2);

    @(negedge CLK);
    #1;
    run = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || held_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got events=%0d held=%0d left want 0 and 0",
               exp_q.size(), held_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
